// File: rtl/wavepool_feed_arbiter_if.sv
// Feed-arbiter bus between wavepool_controller (master) and the arbiter (slave).
// Carries per-wavefront queue status, decode/issue handshakes and the selected feed.
interface wavepool_feed_arbiter_if;
    logic [39:0] valid_wf;
    logic [39:0] q_empty;
    logic [39:0] q_reset;
    logic        decode_ready;
    logic        issue_ack_valid;
    logic [5:0]  issue_ack_wfid;
    logic [5:0]  feed_wfid;
    logic        feed_valid;
    logic [31:0] perf_grant_cnt;
    logic [31:0] perf_stall_cnt;

    modport master (
        output valid_wf, q_empty, q_reset, decode_ready, issue_ack_valid, issue_ack_wfid,
        input  feed_wfid, feed_valid, perf_grant_cnt, perf_stall_cnt
    );

    modport slave (
        input  valid_wf, q_empty, q_reset, decode_ready, issue_ack_valid, issue_ack_wfid,
        output feed_wfid, feed_valid, perf_grant_cnt, perf_stall_cnt
    );
endinterface

// File: rtl/wavepool_feed_arbiter.sv
// Round-robin selection of the wavefront queue that feeds decode, with per-wavefront
// in-flight credits. Optional perf counters are built when FEED_PERF_CNT_EN is defined.
module wavepool_feed_arbiter #(
    parameter int NUM_WF       = 40,
    parameter int MAX_INFLIGHT = 2,
    parameter int CRED_W       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    wavepool_feed_arbiter_if.slave  bus
);

    logic [5:0]        last_grant_q;
    logic [5:0]        last_grant_d;
    logic [CRED_W-1:0] credit_q [NUM_WF];
    logic [CRED_W-1:0] credit_d [NUM_WF];
    logic [NUM_WF-1:0] elig;
    logic [5:0]        winner;
    logic              any_elig;
    logic              grant;

    generate
        for (genvar gi = 0; gi < NUM_WF; gi++) begin : g_wf
            logic inc;
            logic ack_hit;

            assign elig[gi] = bus.valid_wf[gi] & ~bus.q_empty[gi] & ~bus.q_reset[gi]
                            & (credit_q[gi] < CRED_W'(MAX_INFLIGHT));
            assign inc      = grant && (winner == 6'(gi));
            assign ack_hit  = bus.issue_ack_valid && (bus.issue_ack_wfid == 6'(gi));

            // Flush wins over everything; a simultaneous grant and ack cancel out.
            always_comb begin
                credit_d[gi] = credit_q[gi];
                if (bus.q_reset[gi]) begin
                    credit_d[gi] = '0;
                end else if (inc && !ack_hit) begin
                    credit_d[gi] = credit_q[gi] + 1'b1;
                end else if (ack_hit && !inc && (credit_q[gi] != '0)) begin
                    credit_d[gi] = credit_q[gi] - 1'b1;
                end
            end
        end
    endgenerate

    // Scan starts just past the last winner and wraps, so the last winner is checked last.
    always_comb begin
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_WF; k++) begin
            int idx;
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_WF) begin
                idx = idx - NUM_WF;
            end
            if (!found && elig[idx]) begin
                winner = 6'(idx);
                found  = 1'b1;
            end
        end
    end

    assign any_elig = |elig;
    assign grant    = bus.decode_ready & any_elig & ~rst;

    assign bus.feed_valid = grant;
    assign bus.feed_wfid  = grant ? winner : 6'd0;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant) begin
            last_grant_d = winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 6'(NUM_WF - 1);
            for (int i = 0; i < NUM_WF; i++) begin
                credit_q[i] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            credit_q     <= credit_d;
        end
    end

`ifdef FEED_PERF_CNT_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign grant_cnt_d = grant_cnt_q + 32'(grant);
    assign stall_cnt_d = stall_cnt_q + 32'(any_elig & ~bus.decode_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_grant_cnt = grant_cnt_q;
    assign bus.perf_stall_cnt = stall_cnt_q;
`else
    assign bus.perf_grant_cnt = '0;
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_wavepool_feed_arbiter.sv
// Directed bench for wavepool_feed_arbiter: stimulus pushes expected feeds into a
// scoreboard queue, a negedge monitor pops and compares every cycle.
module tb_wavepool_feed_arbiter;

    bit   clk;
    logic rst;

    wavepool_feed_arbiter_if bus ();

    wavepool_feed_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [5:0]  id;
        bit          chk_perf;
        logic [31:0] stall;
        logic [31:0] grnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] perf_exp(input int n);
`ifdef FEED_PERF_CNT_EN
        return 32'(n);
`else
        return (n == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic logic [39:0] wf_set(input int a, input int b);
        logic [39:0] r;
        r = '0;
        if (a >= 0) r[a] = 1'b1;
        if (b >= 0) r[b] = 1'b1;
        return r;
    endfunction

    task automatic cycp(input string nm, input logic ev, input logic [5:0] eid,
                        input bit cp, input int st, input int gr);
        exp_t e;
        e.name = nm; e.v = ev; e.id = eid; e.chk_perf = cp;
        e.stall = perf_exp(st); e.grnt = perf_exp(gr);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic ev, input logic [5:0] eid);
        cycp(nm, ev, eid, 1'b0, 0, 0);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        cycp(nm, 1'b0, 6'd0, 1'b1, 0, 0);
        rst = 1'b0;
    endtask

    // Monitor: one comparison line per transaction, plus perf checks when requested.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if (bus.feed_valid !== e.v || bus.feed_wfid !== e.id) begin
                n_fail++;
                $display("[TB] FAIL %s: got valid=%0b wfid=%0d, want valid=%0b wfid=%0d",
                         e.name, bus.feed_valid, bus.feed_wfid, e.v, e.id);
            end else begin
                $display("[TB] ok   %s: valid=%0b wfid=%0d", e.name, e.v, e.id);
            end
            if (e.chk_perf) begin
                n_tests++;
                if (bus.perf_stall_cnt !== e.stall || bus.perf_grant_cnt !== e.grnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s_perf: got stall=%0d grant=%0d, want stall=%0d grant=%0d",
                             e.name, bus.perf_stall_cnt, bus.perf_grant_cnt, e.stall, e.grnt);
                end else begin
                    $display("[TB] ok   %s_perf: stall=%0d grant=%0d", e.name, e.stall, e.grnt);
                end
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.valid_wf        = '0;
        bus.q_empty         = '0;
        bus.q_reset         = '0;
        bus.decode_ready    = 1'b1;
        bus.issue_ack_valid = 1'b0;
        bus.issue_ack_wfid  = '0;
        @(posedge clk);
        #1;

        // Outputs gated while reset is held, even with eligible work present.
        bus.valid_wf = wf_set(0, 5);
        cycp("rst_gate", 1'b0, 6'd0, 1'b1, 0, 0);
        rst = 1'b0;
        bus.valid_wf = '0;
        cyc("idle", 1'b0, 6'd0);

        // Test 1: first grant after reset starts at wf 0.
        bus.valid_wf = wf_set(0, 5);
        cyc("t1_first", 1'b1, 6'd0);
        cyc("t1_next", 1'b1, 6'd5);
        do_reset("rst_mid");

        // Test 2: round robin between 3 and 7 with acks for the previous grant.
        bus.valid_wf = wf_set(3, 7);
        for (int k = 0; k < 6; k++) begin
            bus.issue_ack_valid = (k > 0);
            bus.issue_ack_wfid  = (k % 2 == 1) ? 6'd3 : 6'd7;
            cyc("t2_rr", 1'b1, (k % 2 == 0) ? 6'd3 : 6'd7);
        end
        bus.issue_ack_valid = 1'b0;
        do_reset("rst_t3");

        // Test 3: wrap from 39 to 0, then credits exhaust.
        bus.valid_wf = wf_set(38, -1);
        cyc("t3_38", 1'b1, 6'd38);
        bus.valid_wf = wf_set(0, 39);
        cyc("t3_39", 1'b1, 6'd39);
        cyc("t3_wrap0", 1'b1, 6'd0);
        cyc("t3_39b", 1'b1, 6'd39);
        cyc("t3_0b", 1'b1, 6'd0);
        cyc("t3_nocred", 1'b0, 6'd0);
        do_reset("rst_t4");

        // Test 4: credit limit on wf5, one ack frees a slot.
        bus.valid_wf = wf_set(5, -1);
        cyc("t4_c0", 1'b1, 6'd5);
        cyc("t4_c1", 1'b1, 6'd5);
        bus.issue_ack_valid = 1'b1;
        bus.issue_ack_wfid  = 6'd5;
        cyc("t4_c2", 1'b0, 6'd0);
        bus.issue_ack_valid = 1'b0;
        cyc("t4_c3", 1'b1, 6'd5);

        // Test 5: flush with simultaneous ack, then stray ack saturates at 0.
        bus.q_reset         = wf_set(5, -1);
        bus.issue_ack_valid = 1'b1;
        cyc("t5_flush", 1'b0, 6'd0);
        bus.q_reset  = '0;
        bus.valid_wf = '0;
        cyc("t5_stray", 1'b0, 6'd0);
        bus.issue_ack_valid = 1'b0;
        bus.valid_wf = wf_set(5, -1);
        cyc("t5_g0", 1'b1, 6'd5);
        cyc("t5_g1", 1'b1, 6'd5);
        cyc("t5_full", 1'b0, 6'd0);
        // Out-of-range ack wfid must not free wf5.
        bus.issue_ack_valid = 1'b1;
        bus.issue_ack_wfid  = 6'd45;
        cyc("t5_ack45", 1'b0, 6'd0);
        bus.issue_ack_valid = 1'b0;
        cyc("t5_still_full", 1'b0, 6'd0);
        // Flush alone clears two credits.
        bus.q_reset = wf_set(5, -1);
        cyc("t5_flush2", 1'b0, 6'd0);
        bus.q_reset = '0;
        cyc("t5_h0", 1'b1, 6'd5);
        cyc("t5_h1", 1'b1, 6'd5);
        cyc("t5_h_full", 1'b0, 6'd0);
        do_reset("rst_same");

        // Grant and ack to the same wavefront leave its credit unchanged.
        bus.valid_wf = wf_set(5, -1);
        cyc("same_g0", 1'b1, 6'd5);
        bus.issue_ack_valid = 1'b1;
        bus.issue_ack_wfid  = 6'd5;
        cyc("same_ga", 1'b1, 6'd5);
        bus.issue_ack_valid = 1'b0;
        cyc("same_g1", 1'b1, 6'd5);
        cyc("same_full", 1'b0, 6'd0);
        do_reset("rst_t6");

        // Test 6: decode stall holds state and counts stall cycles.
        bus.valid_wf     = wf_set(2, -1);
        bus.decode_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc("t6_stall", 1'b0, 6'd0);
        end
        bus.decode_ready = 1'b1;
        cycp("t6_g0", 1'b1, 6'd2, 1'b1, 4, 0);
        cyc("t6_g1", 1'b1, 6'd2);
        cycp("t6_full", 1'b0, 6'd0, 1'b1, 4, 2);

        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
